// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM output block: counter width, channel count,
//   default prescale, the SPI register map (shared with the SPI peripheral),
//   the per-channel drive mode and small helper functions for the level logic.
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int PWM_CNT_W        = 8;
   localparam int PWM_NUM_CH       = 16;
   localparam int PWM_PRESCALE_DEF = 13;

   localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 8'hFF;

   // SPI register map, must stay in step with the SPI register peripheral
   localparam logic [7:0] PWM_ADDR_EN_OUT_7_0  = 8'h00;
   localparam logic [7:0] PWM_ADDR_EN_OUT_15_8 = 8'h01;
   localparam logic [7:0] PWM_ADDR_EN_PWM_7_0  = 8'h02;
   localparam logic [7:0] PWM_ADDR_EN_PWM_15_8 = 8'h03;
   localparam logic [7:0] PWM_ADDR_DUTY        = 8'h04;

   typedef enum logic [1:0] {
      CH_OFF    = 2'd0,
      CH_STATIC = 2'd1,
      CH_PWM    = 2'd2
   } ch_mode_e;

   // Output enable dominates: a disabled channel is low whatever its PWM bit says
   function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
      ch_mode_e mode;
      if (!en_out) begin
         mode = CH_OFF;
      end else if (en_pwm) begin
         mode = CH_PWM;
      end else begin
         mode = CH_STATIC;
      end
      return mode;
   endfunction

   // Duty 255 is forced fully high; a plain compare would give 255/256
   function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                      input logic [PWM_CNT_W-1:0] duty);
      logic lvl;
      if (duty == PWM_CNT_MAX) begin
         lvl = 1'b1;
      end else begin
         lvl = (cnt < duty);
      end
      return lvl;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//   Common timebase for all PWM channels: a prescaler counting 0..PRESCALE-1
//   and an 8-bit PWM counter advanced on each prescaler wrap.
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous reset, active-low
//   pwm_cnt_o        out  current PWM count 0..255
//   tick_o           out  prescaler is in its last cycle (count advances next clk)
//   boundary_o       out  tick in the cycle where pwm_cnt is 255 (period ends)
//   period_start_o   out  registered one-clk pulse, high while pwm_cnt first reads 0
// -----------------------------------------------------------------------------
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [PWM_CNT_W-1:0] pwm_cnt_o,
   output logic                 tick_o,
   output logic                 boundary_o,
   output logic                 period_start_o
);

   // A prescale of 1 still needs a 1-bit register; it simply never leaves 0
   localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]   PS_ONE  = PS_W'(1);
   localparam logic [PWM_CNT_W-1:0] CNT_ONE = PWM_CNT_W'(1);

   logic [PS_W-1:0]      presc_q, presc_d;
   logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
   logic                 period_start_q, period_start_d;
   logic                 tick_s, boundary_s;

   // Prescaler wrap detect and period boundary detect
   always_comb begin
      tick_s     = (presc_q == PS_LAST);
      boundary_s = tick_s && (cnt_q == PWM_CNT_MAX);
   end

   // Next-state for prescaler, PWM counter (natural 255->0 wrap) and period pulse
   always_comb begin
      if (tick_s) begin
         presc_d = '0;
         cnt_d   = cnt_q + CNT_ONE;
      end else begin
         presc_d = presc_q + PS_ONE;
         cnt_d   = cnt_q;
      end
      period_start_d = boundary_s;
   end

   // Timebase state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q        <= '0;
         cnt_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_cnt_o      = cnt_q;
   assign tick_o         = tick_s;
   assign boundary_o     = boundary_s;
   assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//   Drives the 16 chip output pins from the SPI control registers. Each pin is
//   forced low, held static high, or modulated by a shared 8-bit duty cycle on
//   a common timebase (period = 256*PRESCALE clk).
// Configuration macro
//   PWM_SYNC_UPDATE_EN  defined: the active duty is a shadow register loaded
//                       only at the period boundary (glitch-free updates).
//                       undefined: the active duty follows pwm_duty_cycle with
//                       one clk delay; a mid-period write may give one period of
//                       intermediate width.
// Ports
//   clk               in   system clock
//   rst_n             in   asynchronous reset, active-low
//   en_reg_out_7_0    in   output enable, channels 7..0
//   en_reg_out_15_8   in   output enable, channels 15..8
//   en_reg_pwm_7_0    in   PWM-mode select, channels 7..0
//   en_reg_pwm_15_8   in   PWM-mode select, channels 15..8
//   pwm_duty_cycle    in   requested duty cycle 0..255
//   out               out  registered channel outputs
//   period_start      out  one-clk pulse at the start of each PWM period
// -----------------------------------------------------------------------------
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEF,
   parameter int NUM_CH   = PWM_NUM_CH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           en_reg_out_7_0,
   input  logic [7:0]           en_reg_out_15_8,
   input  logic [7:0]           en_reg_pwm_7_0,
   input  logic [7:0]           en_reg_pwm_15_8,
   input  logic [7:0]           pwm_duty_cycle,
   output logic [NUM_CH-1:0]    out,
   output logic                 period_start
);

   logic [PWM_CNT_W-1:0] pwm_cnt_s;
   logic                 tick_s;
   logic                 boundary_s;
   logic                 period_start_s;
   logic                 unused_s;

   logic [PWM_CNT_W-1:0] duty_act_q, duty_act_d;
   logic [NUM_CH-1:0]    out_q, out_d;
   logic [NUM_CH-1:0]    en_out_s, en_pwm_s;
   logic                 pwm_lvl_s;

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk            (clk),
      .rst_n          (rst_n),
      .pwm_cnt_o      (pwm_cnt_s),
      .tick_o         (tick_s),
      .boundary_o     (boundary_s),
      .period_start_o (period_start_s)
   );

   // tick is only needed inside the timebase; boundary only in the shadowed build
   assign unused_s = ^{tick_s, boundary_s};

   assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
   // Shadow duty: take the new value only as the period wraps, so no runt periods
   always_comb begin
      if (boundary_s) begin
         duty_act_d = pwm_duty_cycle;
      end else begin
         duty_act_d = duty_act_q;
      end
   end
`else
   // Follow the duty register every clk; mid-period writes take effect at once
   always_comb begin
      duty_act_d = pwm_duty_cycle;
   end
`endif

   // Active duty register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_act_q <= '0;
      end else begin
         duty_act_q <= duty_act_d;
      end
   end

   // Shared modulated level and per-channel drive selection
   always_comb begin
      pwm_lvl_s = pwm_level(pwm_cnt_s, duty_act_q);
      out_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (ch_mode(en_out_s[i], en_pwm_s[i]))
            CH_OFF:    out_d[i] = 1'b0;
            CH_STATIC: out_d[i] = 1'b1;
            CH_PWM:    out_d[i] = pwm_lvl_s;
            default:   out_d[i] = 1'b0;
         endcase
      end
   end

   // Pin register: enables, duty and count all reach the pins one clk later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_s;

endmodule

// File: tb/tb_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_pwm_generator
//   Directed, self-checking bench for pwm_generator at PRESCALE=13
//   (period 3328 clk). Expected values are hand-derived; the duty-update
//   sequences have separate expectations for the PWM_SYNC_UPDATE_EN build.
//   Outputs are sampled 1 time unit after each rising clock edge; sample k
//   after an edge shows the registered value produced by that edge.
// -----------------------------------------------------------------------------
module tb_pwm_generator;

   localparam int PERIOD = 3328;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out_s;
   logic        period_start_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pwm_generator #(
      .PRESCALE (13),
      .NUM_CH   (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out_s),
      .period_start    (period_start_s)
   );

   typedef struct {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [7:0]  duty;
      logic        sync;      // wait for a period start before checking
      int          cycles;    // length of the check window
      logic [15:0] exp_out;   // constant expected pin value over the window
      string       name;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      en_reg_out_7_0  = eo[7:0];
      en_reg_out_15_8 = eo[15:8];
      en_reg_pwm_7_0  = ep[7:0];
      en_reg_pwm_15_8 = ep[15:8];
      pwm_duty_cycle  = d;
   endtask

   // Advance until a period_start sample is seen; bounded by a bit over one period
   task automatic wait_ps(input string name);
      int found;
      found = 0;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (period_start_s === 1'b1) begin
            found = 1;
            break;
         end
      end
      chk(name, found, 32'd1);
   endtask

   initial begin
      int nz, pcount, badpos, bad, hi, hi1, hi2, hi_first, early;
      logic [31:0] s_a, s_b, s_c, s_d;

      vecs[0] = '{16'h0000, 16'hFFFF, 8'd128, 1'b0, 400,      16'h0000, "tbl_out_off_pwm_on"};
      vecs[1] = '{16'hFFFF, 16'h0000, 8'd128, 1'b0, PERIOD,   16'hFFFF, "tbl_all_static"};
      vecs[2] = '{16'h00FF, 16'h0000, 8'd128, 1'b0, 400,      16'h00FF, "tbl_low_byte_static"};
      vecs[3] = '{16'h8000, 16'h8000, 8'd0,   1'b1, 3*PERIOD, 16'h0000, "tbl_ch15_duty0"};
      vecs[4] = '{16'h8000, 16'h8000, 8'd255, 1'b1, 3*PERIOD, 16'h8000, "tbl_ch15_duty255"};
      vecs[5] = '{16'hFF00, 16'h8000, 8'd255, 1'b0, 400,      16'hFF00, "tbl_mixed_static_pwm"};
      vecs[6] = '{16'hA5A5, 16'h0000, 8'd255, 1'b0, 400,      16'hA5A5, "tbl_pattern_static"};

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      set_cfg(16'h0000, 16'h0000, 8'd128);
      repeat (3) step();
      chk("reset_out", out_s, 32'h0);
      chk("reset_period_start", period_start_s, 32'd0);

      // ------ all enables off, 4 periods: pins stay low, pulses every 3328 ------
      @(negedge clk);
      rst_n = 1'b1;
      nz = 0; pcount = 0; badpos = 0;
      for (int k = 1; k <= 4*PERIOD + 20; k++) begin
         step();
         if (out_s !== 16'h0000) nz++;
         if (period_start_s === 1'b1) begin
            pcount++;
            if ((k % PERIOD) != 0) badpos++;
         end
      end
      chk("idle_out_nonzero_cycles", nz, 32'd0);
      chk("idle_period_start_count", pcount, 32'd4);
      chk("idle_period_start_misplaced", badpos, 32'd0);

      // ---------------- table of constant-output configurations ----------------
      for (int v = 0; v < 7; v++) begin
         set_cfg(vecs[v].en_out, vecs[v].en_pwm, vecs[v].duty);
         if (vecs[v].sync) wait_ps({vecs[v].name, "_sync"});
         bad = 0;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            step();
            if (out_s !== vecs[v].exp_out) bad++;
         end
         chk({vecs[v].name, "_bad_cycles"}, bad, 32'd0);
      end

      // ---------------- channel 0, duty 128: 1664 high / 1664 low ----------------
      set_cfg(16'h0001, 16'h0001, 8'd128);
      wait_ps("d128_sync");
      hi = 0; nz = 0;
      s_a = 0; s_b = 0; s_c = 0; s_d = 0;
      for (int j = 1; j <= PERIOD; j++) begin
         step();
         hi += int'(out_s[0]);
         if (out_s[15:1] !== 15'h0000) nz++;
         if (j == 1)      s_a = out_s[0];
         if (j == 1664)   s_b = out_s[0];
         if (j == 1665)   s_c = out_s[0];
         if (j == PERIOD) s_d = {30'd0, period_start_s, out_s[0]};
      end
      chk("d128_high_count", hi, 32'd1664);
      chk("d128_other_bits", nz, 32'd0);
      chk("d128_first_high", s_a, 32'd1);
      chk("d128_last_high", s_b, 32'd1);
      chk("d128_first_low", s_c, 32'd0);
      chk("d128_next_start_low", s_d, 32'd2);   // period_start=1, out[0]=0
      step();
      chk("d128_rise_after_start", out_s[0], 32'd1);

      // ------------- duty 64 -> 192 written 1000 clk into a period -------------
      pwm_duty_cycle = 8'd64;
      wait_ps("dchg_sync");
      hi1 = 0; hi2 = 0; s_a = 0;
      for (int j = 1; j <= 2*PERIOD; j++) begin
         step();
         if (j <= PERIOD) hi1 += int'(out_s[0]);
         else             hi2 += int'(out_s[0]);
         if (j == 1002)   s_a = out_s[0];
         if (j == 1000)   pwm_duty_cycle = 8'd192;
      end
`ifdef PWM_SYNC_UPDATE_EN
      chk("dchg_cur_period_high", hi1, 32'd832);
      chk("dchg_no_early_update", s_a, 32'd0);
`else
      chk("dchg_cur_period_high", hi1, 32'd2327);
      chk("dchg_fast_update", s_a, 32'd1);
`endif
      chk("dchg_next_period_high", hi2, 32'd2496);

      // ---------------- reset mid-period with out[0] high ----------------
      wait_ps("rst_sync");
      repeat (100) step();
      chk("rst_pre_high", out_s[0], 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out", out_s, 32'h0);
      @(negedge clk);
      step();
      step();
      chk("rst_held_out", {15'd0, period_start_s, out_s}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      early = 0; hi_first = 0; hi = 0;
      s_a = 0; s_b = 0; s_c = 0; s_d = 0;
      for (int k = 1; k <= 2*PERIOD; k++) begin
         step();
         if (k < PERIOD && period_start_s === 1'b1) early++;
         if (k <= PERIOD) hi_first += int'(out_s[0]);
         else             hi += int'(out_s[0]);
         if (k == 1)          s_a = out_s[0];
         if (k == 2)          s_b = out_s[0];
         if (k == PERIOD)     s_c = period_start_s;
         if (k == PERIOD + 1) s_d = out_s[0];
      end
      chk("rst_no_early_period_start", early, 32'd0);
      chk("rst_first_period_start", s_c, 32'd1);
      chk("rst_second_period_high", hi, 32'd2496);
      chk("rst_second_period_rise", s_d, 32'd1);
`ifdef PWM_SYNC_UPDATE_EN
      chk("rst_first_period_high", hi_first, 32'd0);
`else
      chk("rst_first_period_high", hi_first, 32'd2495);
      chk("rst_first_sample_low", s_a, 32'd0);
      chk("rst_high_from_cnt0", s_b, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
